// File: rtl/alu_req_sched_if.sv
// Bundle of requester, ALU-unit and response signals for alu_req_sched.
// The scheduler connects through the slave modport; the environment (hosts, ALU units, consumer) through master.
interface alu_req_sched_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_fun;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_fun;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_fun;
  logic              arith_en;
  logic              logic_en;
  logic              cmp_en;
  logic              shift_en;
  logic [OUT_W-1:0]  alu_result;
  logic              alu_flag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [OUT_W-1:0]  rsp_data;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_fun, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_fun, req1_a, req1_b,
    output req1_ready,
    output alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en,
    input  alu_result, alu_flag,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_fun, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_fun, req1_a, req1_b,
    input  req1_ready,
    input  alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en,
    output alu_result, alu_flag,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one ALU datapath between two requesters, one operation in flight.
// Define ALU_SCHED_TIMEOUT_EN to add a WAIT watchdog that answers with rsp_err after TIMEOUT_CYC cycles.
module alu_req_sched #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
`ifdef ALU_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 15
`endif
) (
  input logic           clk,
  input logic           rst,
  alu_req_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              last;
  logic              grant;
  logic              any_valid;
  logic              accept;
  logic [3:0]        sel_fun;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        fun_q;
  logic [3:0]        en_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [OUT_W-1:0]  rsp_data_q;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;
`endif

  // On a tie the requester not served last time wins; otherwise the lone valid one.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign any_valid      = bus.req0_valid | bus.req1_valid;
  assign accept         = !rst && (state == IDLE) && any_valid;
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  assign sel_fun = grant ? bus.req1_fun : bus.req0_fun;
  assign sel_a   = grant ? bus.req1_a   : bus.req0_a;
  assign sel_b   = grant ? bus.req1_b   : bus.req0_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      en_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
      wait_cnt    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            fun_q    <= sel_fun[1:0];
            en_q     <= 4'b0001 << sel_fun[3:2];
            rsp_id_q <= grant;
            last     <= grant;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          en_q  <= '0;
          state <= WAIT;
`ifdef ALU_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        // Units clear their output once disabled, so the flagged cycle is the only capture chance.
        WAIT: begin
          if (bus.alu_flag) begin
            rsp_data_q  <= bus.alu_result;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
`ifdef ALU_SCHED_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
`ifdef ALU_SCHED_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_fun   = fun_q;
  assign bus.arith_en  = en_q[0];
  assign bus.logic_en  = en_q[1];
  assign bus.cmp_en    = en_q[2];
  assign bus.shift_en  = en_q[3];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef ALU_SCHED_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched with a small registered ALU-unit model on the unit side.
// Covers the ALU_SCHED_TIMEOUT_EN build as well as the default one.
module tb_alu_req_sched;

  logic clk;
  logic rst;
  logic flag_kill;
  int   errors;
  int   checks;

  localparam logic [7:0]  R0A [4] = '{8'h01, 8'h10, 8'h05, 8'h40};
  localparam logic [7:0]  R0B [4] = '{8'h02, 8'h20, 8'h05, 8'h01};
  localparam logic [15:0] R0E [4] = '{16'h0003, 16'h0030, 16'h000A, 16'h0041};
  localparam logic [7:0]  R1A [4] = '{8'hF0, 8'hFF, 8'hAA, 8'hC3};
  localparam logic [7:0]  R1B [4] = '{8'h3C, 8'h0F, 8'h55, 8'h81};
  localparam logic [15:0] R1E [4] = '{16'h0030, 16'h000F, 16'h0000, 16'h0081};

  alu_req_sched_if #(.DATA_W(8), .OUT_W(16)) bus ();

  alu_req_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit outputs: result and flag register one cycle after an enable, zero otherwise.
  function automatic logic [15:0] unit_out(input logic [3:0] en, input logic [1:0] f,
                                           input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    if (en[0]) begin
      case (f)
        2'b00: r = a + b;
        2'b01: r = a - b;
        2'b10: r = a + 8'h01;
        default: r = -a;
      endcase
    end else if (en[1]) begin
      case (f)
        2'b00: r = a & b;
        2'b01: r = a | b;
        2'b10: r = a ^ b;
        default: r = ~a;
      endcase
    end else if (en[2]) begin
      case (f)
        2'b00: r = {7'd0, $signed(a) < $signed(b)};
        2'b01: r = {7'd0, a == b};
        2'b10: r = {6'd0, $signed(a) > $signed(b), a == b};
        default: r = {7'd0, a < b};
      endcase
    end else if (en[3]) begin
      case (f)
        2'b00: r = a << b[2:0];
        2'b01: r = a >> b[2:0];
        2'b10: r = $signed(a) >>> b[2:0];
        default: r = {a[6:0], a[7]};
      endcase
    end
    return {8'h00, r};
  endfunction

  always @(posedge clk) begin
    if (flag_kill) begin
      bus.alu_flag   <= 1'b0;
      bus.alu_result <= 16'h0000;
    end else begin
      bus.alu_flag   <= bus.arith_en | bus.logic_en | bus.cmp_en | bus.shift_en;
      bus.alu_result <= unit_out({bus.shift_en, bus.cmp_en, bus.logic_en, bus.arith_en},
                                 bus.alu_fun, bus.alu_a, bus.alu_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (!bus.rsp_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flag_kill = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_fun = 4'h0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_fun = 4'h0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_err} !== 4'b0000)
      $display("[TB] FAIL reset_handshake: got %b expected 0000",
               {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_err});
    if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_err} !== 4'b0000) errors++;
    checks++;
    if ({bus.arith_en, bus.logic_en, bus.cmp_en, bus.shift_en} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_enables: got %b expected 0000",
               {bus.arith_en, bus.logic_en, bus.cmp_en, bus.shift_en});
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_data} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got id=%b data=%h expected id=0 data=0000", bus.rsp_id, bus.rsp_data);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_operands: got a=%h b=%h fun=%b expected zeros", bus.alu_a, bus.alu_b, bus.alu_fun);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_cmp();
    bus.req0_valid = 1'b1; bus.req0_fun = 4'b1010; bus.req0_a = 8'h09; bus.req0_b = 8'h03;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL cmp_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if ({bus.arith_en, bus.logic_en, bus.cmp_en, bus.shift_en, bus.alu_a, bus.alu_b, bus.alu_fun} !==
        {4'b0010, 8'h09, 8'h03, 2'b10}) begin
      errors++;
      $display("[TB] FAIL cmp_issue: got en=%b a=%h b=%h fun=%b expected en=0010 a=09 b=03 fun=10",
               {bus.arith_en, bus.logic_en, bus.cmp_en, bus.shift_en}, bus.alu_a, bus.alu_b, bus.alu_fun);
    end
    tick();
    checks++;
    if ({bus.cmp_en, bus.rsp_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL cmp_wait: got cmp_en,rsp_valid=%b expected 00", {bus.cmp_en, bus.rsp_valid});
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, 1'b0, 16'h0002, 1'b0}) begin
      errors++;
      $display("[TB] FAIL cmp_rsp: got valid=%b id=%b data=%h err=%b expected 1 0 0002 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cmp_release: got rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_eq_false();
    int n;
    bus.req1_valid = 1'b1; bus.req1_fun = 4'b1001; bus.req1_a = 8'h05; bus.req1_b = 8'h06;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL eq_ready: got %b expected 01", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(20, n);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 16'h0000} || n != 2) begin
      errors++;
      $display("[TB] FAIL eq_rsp: got valid=%b id=%b data=%h after %0d cycles expected 1 1 0000 after 2",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, n);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int i0, i1, who, n;
    logic [15:0] exp_data;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i0 = 0; i1 = 0;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_fun = 4'b0000; bus.req0_a = R0A[0]; bus.req0_b = R0B[0];
    bus.req1_valid = 1'b1; bus.req1_fun = 4'b0100; bus.req1_a = R1A[0]; bus.req1_b = R1B[0];
    #1;
    for (int k = 0; k < 8; k++) begin
      who = -1;
      for (int c = 0; c < 20 && who < 0; c++) begin
        if (bus.req0_ready) who = 0;
        else if (bus.req1_ready) who = 1;
        else tick();
      end
      checks++;
      if (who != k % 2) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: got requester %0d expected %0d", k, who, k % 2);
      end
      if (who < 0) break;
      tick();
      if (who == 0) begin
        i0++;
        if (i0 < 4) begin bus.req0_a = R0A[i0]; bus.req0_b = R0B[i0]; end
        else bus.req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 4) begin bus.req1_a = R1A[i1]; bus.req1_b = R1B[i1]; end
        else bus.req1_valid = 1'b0;
      end
      exp_data = (k % 2 == 0) ? R0E[k / 2] : R1E[k / 2];
      wait_rsp(20, n);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(k % 2) || bus.rsp_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL rr_rsp%0d: got valid=%b id=%b data=%h expected 1 %0d %h",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % 2, exp_data);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int n;
    bit held;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_fun = 4'b0101; bus.req0_a = 8'h0F; bus.req0_b = 8'h30;
    #1;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_fun = 4'b0000; bus.req1_a = 8'h01; bus.req1_b = 8'h01;
    wait_rsp(20, n);
    held = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req0_ready, bus.req1_ready} !==
          {1'b1, 1'b0, 16'h003F, 2'b00}) held = 1'b0;
      tick();
    end
    checks++;
    if (!held) begin
      errors++;
      $display("[TB] FAIL stall_hold: got valid=%b id=%b data=%h readys=%b expected 1 0 003F 00",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, {bus.req0_ready, bus.req1_ready});
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL stall_release: got rsp_valid,req1_ready=%b expected 01", {bus.rsp_valid, bus.req1_ready});
    end
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(20, n);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 16'h0002} || n != 2) begin
      errors++;
      $display("[TB] FAIL back_to_back: got valid=%b id=%b data=%h after %0d expected 1 1 0002 after 2",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, n);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int n;
    bus.req0_valid = 1'b1; bus.req0_fun = 4'b1100; bus.req0_a = 8'h03; bus.req0_b = 8'h02;
    #1;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_fun = 4'b0001; bus.req1_a = 8'h20; bus.req1_b = 8'h05;
    #1;
    checks++;
    if ({bus.arith_en, bus.logic_en, bus.cmp_en, bus.shift_en, bus.req0_ready, bus.req1_ready, bus.rsp_valid}
        !== 7'b0) begin
      errors++;
      $display("[TB] FAIL rst_wait: got en=%b readys=%b rsp_valid=%b expected all 0",
               {bus.arith_en, bus.logic_en, bus.cmp_en, bus.shift_en},
               {bus.req0_ready, bus.req1_ready}, bus.rsp_valid);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rst_recover: got rsp_valid,req1_ready=%b expected 01", {bus.rsp_valid, bus.req1_ready});
    end
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(20, n);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 16'h001B} || n != 2) begin
      errors++;
      $display("[TB] FAIL rst_next_rsp: got valid=%b id=%b data=%h after %0d expected 1 1 001B after 2",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, n);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit stuck;
    flag_kill = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_fun = 4'b1000; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
    #1;
    tick();
    bus.req0_valid = 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
    wait_rsp(40, n);
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {1'b1, 1'b1, 16'h0000} || n != 16) begin
      errors++;
      $display("[TB] FAIL timeout_rsp: got valid=%b err=%b data=%h after %0d expected 1 1 0000 after 16",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, n);
    end
    tick();
    stuck = 1'b0;
`else
    bus.req1_valid = 1'b1; bus.req1_fun = 4'b0000; bus.req1_a = 8'h01; bus.req1_b = 8'h01;
    stuck = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_err} !== 4'b0000) stuck = 1'b0;
      tick();
    end
    n = 0;
    checks++;
    if (!stuck) begin
      errors++;
      $display("[TB] FAIL no_timeout_wait: got rsp_valid=%b readys=%b err=%b expected stuck in WAIT",
               bus.rsp_valid, {bus.req0_ready, bus.req1_ready}, bus.rsp_err);
    end
    rst = 1'b1;
    bus.req1_valid = 1'b0;
    tick();
    rst = 1'b0;
`endif
    flag_kill = 1'b0;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_cmp();
    test_eq_false();
    test_round_robin();
    test_stall();
    test_reset_in_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_req_sched.md
# alu_req_sched

Two-port round-robin scheduler that shares one signed-ALU datapath (arithmetic, logic, compare and shift units) between two requesters. It accepts an operation per requester over a valid/ready handshake, decodes the 4-bit function into a one-hot unit enable plus the 2-bit unit function, and captures the registered unit result on the cycle its flag rises. It returns the result with the requester ID over a valid/ready response channel. It sits between the instruction front-end/host ports and the ALU units.

## Interface
- DATA_W, 8, operand width
- OUT_W, 16, ALU result width (unit outputs zero-extended to OUT_W)
- TIMEOUT_CYC, 15, max WAIT cycles before error (used only with the macro)
- clk  in  1  clock, all flops rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_fun / req1_fun  in  4  [3:2] unit select: 00 arith, 01 logic, 10 cmp, 11 shift; [1:0] unit function
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- alu_a, alu_b  out  DATA_W  latched operands to units
- alu_fun  out  2  latched fun[1:0]
- arith_en, logic_en, cmp_en, shift_en  out  1  one-hot unit enables
- alu_result  in  OUT_W  OR of unit outputs (disabled units drive 0)
- alu_flag  in  1  OR of unit flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  OUT_W  captured result
- rsp_err  out  1  watchdog expired; rsp_data = 0

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = the only valid requester. If both are valid, grant goes to the requester not granted last time (`last` pointer). `reqN_ready` = (state==IDLE) && grant==N, combinational. On a handshake:
  - latch A, B and fun.
  - latch the ID.
  - update `last`.
  - go to ISSUE.
- ISSUE: exactly one enable high, selected by fun[3:2]. Then go to WAIT.
- WAIT: all enables low. Operands and alu_fun are held. If alu_flag=1, capture alu_result into rsp_data and go to RESP. Units clear their output when disabled, so capture happens only in this cycle.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err are stable until rsp_ready=1. Then go to IDLE.
- Only one operation is in flight. Both ready outputs are low outside IDLE.
- Reset values:
  - state=IDLE, `last`=1 (req0 wins the first tie).
  - all enables, readys, rsp_valid, rsp_err = 0.
  - rsp_id=0, rsp_data=0, alu_a=alu_b=0, alu_fun=0.

## Timing
- Handshake at edge e0. ISSUE occupies e0→e1. Unit registers at e1 and alu_flag=1 during e1→e2. Capture at e2; rsp_valid=1 from e2.
- Nominal acceptance-to-response latency: 2 cycles. Minimum back-to-back spacing: 4 cycles (RESP with rsp_ready=1 → IDLE → next handshake).
- A request valid while the scheduler is busy waits. It is never dropped, and its valid must stay asserted until ready.
- Simultaneous req0/req1 handshake: impossible, because grant is exclusive.
- rsp_ready held low: the scheduler stalls in RESP indefinitely with outputs frozen.
- rst asserted in any state: immediate return to IDLE. The in-flight operation is discarded with no response, and enables drop asynchronously.

## Configuration
- `ALU_SCHED_TIMEOUT_EN` defined:
  - a WAIT counter (width ≥ clog2(TIMEOUT_CYC+1)) clears on ISSUE and increments each WAIT cycle without a flag.
  - when it reaches TIMEOUT_CYC, go to RESP with rsp_err=1 and rsp_data=0.
- Not defined: no counter. WAIT lasts until alu_flag; rsp_err is tied to 0.

## Test plan
- Single compare request: req0 fun=4'b1010, A=8'h09, B=8'h03 → cmp_en high for exactly 1 cycle, rsp_valid 2 cycles after the handshake, rsp_id=0, rsp_data=16'h0002, rsp_err=0.
- Equal-compare false case: req1 fun=4'b1001, A=8'h05, B=8'h06 → rsp_id=1, rsp_data=16'h0000.
- Both requesters valid continuously from reset, each with 4 ops → grant order 0,1,0,1,…; no requester is served twice while the other waits.
- rsp_ready held low for 5 cycles → rsp_valid, rsp_id and rsp_data stay constant and both readys stay low; a single handshake then releases the scheduler to IDLE.
- Reset asserted during WAIT → all enables, readys and rsp_valid are 0 that cycle; the next request gets a correct response and the old one never appears.
- With the macro defined and alu_flag tied 0 → rsp_valid with rsp_err=1 and rsp_data=0 after 1+15 cycles in ISSUE/WAIT. Without the macro → the scheduler stays in WAIT.
